// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM state encoding and a sizing helper for the
// instruction/data port arbiter in front of the unified memory.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_I_ISSUE = 3'd1,
    ARB_I_WAIT  = 3'd2,
    ARB_D_ISSUE = 3'd3,
    ARB_D_WAIT  = 3'd4
  } arb_state_e;

  // Bits needed to hold 0..max inclusive, never less than one.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (I/D) and memory-macro signals of the arbiter, bundled.
// slave = arbiter view, master = pipeline + memory view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_stall;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mem_port_arbiter_sat_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < WIDTH'(MAX))) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data has priority over fetch, bounded by a
// starvation guard; each access runs IDLE -> ISSUE -> WAIT -> IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starved;
  logic              grant_i, grant_d;
  logic              starve_inc, starve_clr;
  logic              i_complete, d_complete;

  logic              mem_en_q, mem_wr_q, i_done_q, d_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  // Fetch is forced once data has won STARVE_MAX grants in a row over it.
  assign starved = (starve_cnt >= CNT_W'(STARVE_MAX)) && bus.i_req;

  always_comb begin
    // NOTE: every signal driven here is defaulted first so no path infers a latch.
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.d_req && !starved) begin
          grant_d = 1'b1;
          state_d = ARB_D_ISSUE;
        end else if (bus.i_req) begin
          grant_i = 1'b1;
          state_d = ARB_I_ISSUE;
        end
      end
      ARB_I_ISSUE: state_d = ARB_I_WAIT;
      ARB_D_ISSUE: state_d = ARB_D_WAIT;
      ARB_I_WAIT, ARB_D_WAIT: begin
        if (bus.mem_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  assign starve_inc = grant_d && bus.i_req;
  assign starve_clr = grant_i || ((state_q == ARB_IDLE) && !bus.i_req);

  mem_port_arbiter_sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt)
  );

  // mem_valid only counts in a WAIT state; strays elsewhere are dropped.
  assign i_complete = (state_q == ARB_I_WAIT) && bus.mem_valid;
  assign d_complete = (state_q == ARB_D_WAIT) && bus.mem_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q <= grant_i || grant_d;
      i_done_q <= i_complete;
      d_done_q <= d_complete;
      if (grant_d) begin
        mem_wr_q    <= bus.d_wr;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
        mem_wr_q    <= 1'b0;
        mem_addr_q  <= bus.i_addr;
        mem_wdata_q <= '0;
      end
      if (i_complete)              i_rdata_q <= bus.mem_rdata;
      if (d_complete && !mem_wr_q) d_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_stall   = bus.i_req && !i_done_q;
  assign bus.d_stall   = bus.d_req && !d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-4 memory model, a transaction-
// level reference model compared every cycle, and literal per-scenario checks.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 2;
  localparam int LATENCY    = 4;
  localparam int LIMIT      = 60;

  logic clk;
  logic rst;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_str(input string name, input string actual, input string expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, actual, expected);
    end
  endtask

  // ---------------- memory macro model ----------------
  logic [15:0] mem [0:65535];
  logic        model_valid = 1'b0;
  logic [15:0] model_rdata = '0;
  logic        stray_valid = 1'b0;
  logic [15:0] stray_rdata = '0;

  assign bus.mem_valid = model_valid || stray_valid;
  assign bus.mem_rdata = model_valid ? model_rdata : stray_rdata;

  initial begin : memory_model
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (bus.mem_en) begin
        a = bus.mem_addr;
        if (bus.mem_wr) mem[a] = bus.mem_wdata;
        repeat (LATENCY) @(posedge clk);
        #1;
        model_rdata = mem[a];
        model_valid = 1'b1;
        @(posedge clk);
        #1;
        model_valid = 1'b0;
      end
    end
  end

  // ---------------- transaction-level reference model + compare ----------------
  bit          m_busy = 0, m_port_d = 0, m_wr = 0, m_exp_done = 0;
  bit          m_prev_idle = 0, m_prev_i = 0, m_prev_d = 0, m_prev_dwr = 0;
  int          m_starve = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_exp_data = '0;
  logic [15:0] m_prev_iaddr = '0, m_prev_daddr = '0, m_prev_dwdata = '0;
  logic [15:0] m_i_rdata = '0, m_d_rdata = '0;
  int          n_issue = 0, n_i_done = 0, n_d_done = 0;
  string       grant_log = "";

  initial begin : compare
    bit exp_i_done, exp_d_done, exp_en, pick_d;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_outputs_zero",
              32'(|{bus.mem_en, bus.mem_wr, bus.i_done, bus.d_done,
                    bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata}), 32'd0);
        m_busy = 0; m_exp_done = 0; m_starve = 0; m_prev_idle = 0;
        m_i_rdata = '0; m_d_rdata = '0;
      end else begin
        // Completion: done pulses the cycle after mem_valid arrived during a wait.
        exp_i_done = m_exp_done && !m_port_d;
        exp_d_done = m_exp_done && m_port_d;
        check("i_done", bus.i_done, exp_i_done);
        check("d_done", bus.d_done, exp_d_done);
        if (bus.i_done) n_i_done++;
        if (bus.d_done) n_d_done++;
        if (m_exp_done) begin
          if (!m_port_d)  m_i_rdata = m_exp_data;
          else if (!m_wr) m_d_rdata = m_exp_data;
          m_busy = 0;
          m_exp_done = 0;
        end
        // Issue: an idle cycle with any request is followed by exactly one issue.
        exp_en = m_prev_idle && (m_prev_i || m_prev_d);
        check("mem_en", bus.mem_en, exp_en);
        if (bus.mem_en) begin
          n_issue++;
          if (bus.mem_addr[15:8] == 8'h03) grant_log = {grant_log, "D"};
          else                             grant_log = {grant_log, "I"};
        end
        if (exp_en) begin
          pick_d = m_prev_d && (m_starve < STARVE_MAX || !m_prev_i);
          if (pick_d) begin
            m_addr  = m_prev_daddr;
            m_wr    = m_prev_dwr;
            m_wdata = m_prev_dwdata;
            if (m_prev_i) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
          end else begin
            m_addr   = m_prev_iaddr;
            m_wr     = 0;
            m_starve = 0;
          end
          m_port_d = pick_d;
          m_busy   = 1;
        end
        if (m_busy) begin
          check("mem_addr", bus.mem_addr, m_addr);
          check("mem_wr", bus.mem_wr, m_wr);
          if (m_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (m_busy && !exp_en && bus.mem_valid) begin
          m_exp_done = 1;
          m_exp_data = mem[m_addr];
        end
        check("i_rdata", bus.i_rdata, m_i_rdata);
        check("d_rdata", bus.d_rdata, m_d_rdata);
        check("i_stall", bus.i_stall, bus.i_req && !exp_i_done);
        check("d_stall", bus.d_stall, bus.d_req && !exp_d_done);
        m_prev_idle = !m_busy;
        if (!m_busy && !bus.i_req) m_starve = 0;
        m_prev_i      = bus.i_req;
        m_prev_d      = bus.d_req;
        m_prev_iaddr  = bus.i_addr;
        m_prev_daddr  = bus.d_addr;
        m_prev_dwr    = bus.d_wr;
        m_prev_dwdata = bus.d_wdata;
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic i_access(input logic [15:0] addr, output int lat);
    int start = int'(cyc);
    int waited = 0;
    bit got = 0;
    bus.i_addr = addr;
    bus.i_req  = 1'b1;
    while (!got && waited < LIMIT) begin
      tick();
      waited++;
      got = bus.i_done;
    end
    bus.i_req = 1'b0;
    lat = int'(cyc) - start;
    check("i_access_in_time", 32'(got), 32'd1);
  endtask

  task automatic d_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat);
    int start = int'(cyc);
    int waited = 0;
    bit got = 0;
    bus.d_wr    = wr;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    while (!got && waited < LIMIT) begin
      tick();
      waited++;
      got = bus.d_done;
    end
    bus.d_req = 1'b0;
    lat = int'(cyc) - start;
    check("d_access_in_time", 32'(got), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int lat_i, lat_d, lat_tmp, before_i, before_d, before_issue;
    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0012] = 16'h5A5A;
    mem[16'h0300] = 16'hBEEF;
    mem[16'h0301] = 16'h1111;
    mem[16'h0302] = 16'h2222;
    mem[16'h0303] = 16'h3333;
    #2 rst = 1'b1;
    #1;
    check("reset_mem_en", bus.mem_en, 1'b0);
    check("reset_i_done", bus.i_done, 1'b0);
    check("reset_d_rdata", bus.d_rdata, 16'h0000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1. fetch only
    before_issue = n_issue;
    i_access(16'h0010, lat_i);
    check("t1_latency", lat_i, 6);
    check("t1_i_rdata", bus.i_rdata, 16'hA5A5);
    check("t1_single_issue", n_issue - before_issue, 1);

    // 2. store, then fetch the stored word back
    d_access(1'b1, 16'h0200, 16'h1234, lat_d);
    check("t2_store_latency", lat_d, 6);
    check("t2_mem_written", mem[16'h0200], 16'h1234);
    check("t2_d_rdata_kept", bus.d_rdata, 16'h0000);
    i_access(16'h0200, lat_i);
    check("t2_readback", bus.i_rdata, 16'h1234);

    // 3. simultaneous requests: data first
    fork
      i_access(16'h0012, lat_i);
      d_access(1'b0, 16'h0300, 16'h0000, lat_d);
    join
    check("t3_d_latency", lat_d, 6);
    check("t3_d_before_i_by_6", 32'(lat_i - lat_d >= 6), 32'd1);
    check("t3_d_rdata", bus.d_rdata, 16'hBEEF);
    check("t3_i_rdata", bus.i_rdata, 16'h5A5A);

    // 4. starvation guard with both sides requesting continuously
    tick();
    grant_log = "";
    fork
      begin
        for (int k = 0; k < 4; k++) d_access(1'b0, 16'h0300 + 16'(k), 16'h0000, lat_tmp);
      end
      begin
        i_access(16'h0010, lat_tmp);
        i_access(16'h0012, lat_tmp);
      end
    join
    check_str("t4_grant_order", grant_log, "DDIDDI");
    check("t4_d_rdata", bus.d_rdata, 16'h3333);
    check("t4_i_rdata", bus.i_rdata, 16'h5A5A);

    // 5. reset in the middle of a data wait
    tick();
    before_d = n_d_done;
    bus.d_wr = 1'b0; bus.d_addr = 16'h0300; bus.d_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    bus.d_req = 1'b0;
    #1;
    check("t5_mem_addr_cleared", bus.mem_addr, 16'h0000);
    check("t5_d_rdata_cleared", bus.d_rdata, 16'h0000);
    check("t5_i_rdata_cleared", bus.i_rdata, 16'h0000);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("t5_no_d_done", n_d_done - before_d, 0);
    d_access(1'b0, 16'h0300, 16'h0000, lat_d);
    check("t5_fresh_latency", lat_d, 6);
    check("t5_fresh_d_rdata", bus.d_rdata, 16'hBEEF);

    // 6. stray mem_valid while idle
    tick();
    before_i = n_i_done;
    before_d = n_d_done;
    stray_rdata = 16'hDEAD;
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    repeat (3) tick();
    check("t6_no_i_done", n_i_done - before_i, 0);
    check("t6_no_d_done", n_d_done - before_d, 0);
    check("t6_i_rdata_kept", bus.i_rdata, 16'h0000);
    check("t6_d_rdata_kept", bus.d_rdata, 16'hBEEF);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not finish, expected completion before time 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
